ks_prefix_pipe: RTL and testbench
=================================

Name: ks_prefix_pipe

Overview:
- Pipelined Kogge-Stone prefix network and sum stage.
- Sits directly downstream of the per-bit propagate/generate stage. Consumes its N-bit p (a^b) and g (a&b) vectors plus a carry-in, and produces the N-bit sum and carry-out.
- One register stage per prefix level, with a valid/ready handshake so the adder can be placed on a stallable datapath.

Parameters:
- N, 16, operand width; must be a power of two, 2..64.
- LEVELS, $clog2(N), prefix levels. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  p/g/cin valid this cycle
- in_ready  output  1  block can accept this cycle
- p  input  N  propagate vector from PG stage
- g  input  N  generate vector from PG stage
- cin  input  1  carry-in
- out_valid  output  1  sum/cout valid
- out_ready  input  1  consumer accepts this cycle
- sum  output  N  p ^ carries
- cout  output  1  carry out of bit N-1

Behaviour:
- Reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n=0: every stage valid bit = 0, out_valid=0, sum=0, cout=0, all stage data registers = 0.
  - in_ready=1 as soon as reset deasserts.
- Pipeline:
  - Stages S0..S_LEVELS, each holding valid, G[N], P[N], p_orig[N], cin.
- S0 capture on accept:
  - G[0] = g[0] | (p[0] & cin); G[i] = g[i] for i>0.
  - P = p; p_orig = p; cin stored.
- Level k (1..LEVELS), span d = 2^(k-1), Sk from S(k-1):
  - For i >= d: G'[i] = G[i] | (P[i] & G[i-d]); P'[i] = P[i] & P[i-d].
  - For i < d: pass through unchanged.
  - p_orig and cin pass through.
- Output from S_LEVELS, purely combinational:
  - c[0] = cin; c[i] = G[i-1] for i = 1..N-1.
  - sum[i] = p_orig[i] ^ c[i]; cout = G[N-1].
  - out_valid = S_LEVELS.valid.
- Handshake:
  - adv = ~S_LEVELS.valid | out_ready.
  - in_ready = adv. This is a combinational path from out_ready and is allowed.
  - Accept = in_valid & in_ready.
  - On adv=1 every stage loads from its predecessor; S0 loads valid = in_valid.
  - On adv=0 every stage holds; no bubble collapsing.
- Latency and throughput:
  - Accept at edge t produces out_valid at edge t+LEVELS (N=16: 4 cycles after capture).
  - Throughput 1 result/cycle when out_ready=1.
- Stall rules:
  - Data registers of an invalid stage may load freely; outputs are defined only when out_valid=1.
  - While out_valid=1 and out_ready=0, sum/cout are stable until accepted.
  - Simultaneous accept and output transfer in one cycle is legal and loses nothing.
- Reset mid-operation clears all in-flight results; no output is produced for them.
- Arithmetic is modulo 2^N; overflow is reported only through cout.

Decomposition:
- Package ks_pkg:
  - localparam KS_N_DEFAULT = 16.
  - Packed struct ks_stage_t {logic valid; logic [N-1:0] G, P, p_orig; logic cin;} (width-parameterised via typedef in module, or fixed at max 64 with masking).
  - Function ks_span(k) returning 2^(k-1).
- Sub-module ks_prefix_cell: combinational black cell (Gi,Pi,Gj,Pj → G',P').
  - Instantiated per bit per level in a generate loop.
  - Gray-cell behaviour falls out because P is unused at the output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-stream with 2 items in flight, release → out_valid=0, sum=0, cout=0, in_ready=1, and no stale result ever appears.
- Full-propagate ripple: p=0xFFFF, g=0x0000, cin=1 (a=0xFFFF, b=0) → 4 cycles after capture sum=0x0000, cout=1.
- Generate at bit 0: p=0xFFFE, g=0x0001, cin=0 (a=0xFFFF, b=0x0001) → sum=0x0000, cout=1. Then p=0x5555, g=0x0000, cin=0 → sum=0x5555, cout=0.
- Back-to-back throughput: 100 random a,b,cin pairs converted to p/g in the bench, in_valid=1, out_ready=1 → 100 consecutive out_valid cycles, each sum/cout equal to a+b+cin.
- Backpressure: out_ready=0 for 6 cycles while feeding → in_ready drops once out_valid=1, sum held stable, no item lost or duplicated; order preserved after out_ready returns.
- Random stress: random in_valid/out_ready toggling, 10k items → scoreboard match and no deadlock.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone prefix adder.
package ks_pkg;

    localparam int KS_N_DEFAULT = 16;

    // Distance between combined bit positions at prefix level k (k >= 1).
    function automatic int ks_span(input int k);
        return 1 << (k - 1);
    endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: merges the (G,P) pair of a span with the adjacent lower span.
module ks_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/ks_prefix_pipe.sv
// Pipelined Kogge-Stone prefix network with sum stage; one register per prefix level,
// whole pipeline advances together under a valid/ready handshake.
module ks_prefix_pipe
    import ks_pkg::*;
#(
    parameter  int N      = KS_N_DEFAULT,
    localparam int LEVELS = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
);

    typedef struct packed {
        logic         valid;
        logic [N-1:0] G;
        logic [N-1:0] P;
        logic [N-1:0] p_orig;
        logic         cin;
    } ks_stage_t;

    ks_stage_t stage_q [0:LEVELS];
    ks_stage_t stage_d [0:LEVELS];
    logic      adv;

    assign adv      = ~stage_q[LEVELS].valid | out_ready;
    assign in_ready = adv;

    // S0: fold carry-in into bit 0 so the prefix network never needs it again
    assign stage_d[0] = '{
        valid:  in_valid,
        G:      g | {{(N-1){1'b0}}, p[0] & cin},
        P:      p,
        p_orig: p,
        cin:    cin
    };

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int D = ks_span(k);
        logic [N-1:0] g_nxt;
        logic [N-1:0] p_nxt;

        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= D) begin : g_cell
                ks_prefix_cell u_cell (
                    .g_hi  (stage_q[k-1].G[i]),
                    .p_hi  (stage_q[k-1].P[i]),
                    .g_lo  (stage_q[k-1].G[i-D]),
                    .p_lo  (stage_q[k-1].P[i-D]),
                    .g_out (g_nxt[i]),
                    .p_out (p_nxt[i])
                );
            end else begin : g_pass
                assign g_nxt[i] = stage_q[k-1].G[i];
                assign p_nxt[i] = stage_q[k-1].P[i];
            end
        end

        assign stage_d[k] = '{
            valid:  stage_q[k-1].valid,
            G:      g_nxt,
            P:      p_nxt,
            p_orig: stage_q[k-1].p_orig,
            cin:    stage_q[k-1].cin
        };
    end

    // Stage registers: all levels load together or hold together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k <= LEVELS; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Output: G[i-1] of the final level is the carry into bit i
    assign out_valid = stage_q[LEVELS].valid;
    assign sum       = stage_q[LEVELS].p_orig ^ {stage_q[LEVELS].G[N-2:0], stage_q[LEVELS].cin};
    assign cout      = stage_q[LEVELS].G[N-1];

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Bench for ks_prefix_pipe: expected results come from p + 2*g + cin (== a + b + cin) in a FIFO model.
module tb_ks_prefix_pipe;

    localparam int N      = 16;
    localparam int LEVELS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] p;
    logic [N-1:0] g;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;

    ks_prefix_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .g         (g),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] total;
        int         cap_step;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    step_no  = 0;
    int    accepted = 0;
    int    popped   = 0;
    bit    lat_check = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, then observe and update the model
    // for the transfers that the next rising edge will perform.
    task automatic step(input logic iv, input logic [N-1:0] pv, input logic [N-1:0] gv,
                        input logic c, input logic ordy);
        item_t it;
        @(negedge clk);
        in_valid  = iv;
        p         = pv;
        g         = gv;
        cin       = c;
        out_ready = ordy;
        #1;
        step_no++;
        if (in_ready !== (!out_valid || out_ready))
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_output", 32'd1, 32'd0);
            end else begin
                chk("sum", {16'd0, sum}, {16'd0, q[0].total[N-1:0]});
                chk("cout", {31'd0, cout}, {31'd0, q[0].total[N]});
                if (lat_check)
                    chk("latency", step_no - q[0].cap_step, LEVELS + 1);
                if (out_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            it.total    = {1'b0, pv} + {gv, 1'b0} + {{N{1'b0}}, c};
            it.cap_step = step_no;
            q.push_back(it);
            accepted++;
        end
    endtask

    task automatic step_ab(input logic iv, input logic ordy);
        logic [N-1:0] a, b;
        a = N'($urandom);
        b = N'($urandom);
        step(iv, a ^ b, a & b, 1'($urandom), ordy);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int base;
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        p         = '0;
        g         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed carry cases with latency checking
        lat_check = 1'b1;
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        step(1'b1, 16'hFFFE, 16'h0001, 1'b0, 1'b1);
        step(1'b1, 16'h5555, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1);
        step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
        drain(20);

        // Back-to-back throughput
        base = popped;
        for (int i = 0; i < 100; i++) step_ab(1'b1, 1'b1);
        drain(20);
        chk("tput_count", popped - base, 100);
        lat_check = 1'b0;

        // Backpressure: consumer stalls while the producer keeps offering
        for (int i = 0; i < 6; i++) step_ab(1'b1, 1'b0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) step_ab(1'b1, 1'b0);
        drain(20);

        // Reset mid-stream with two items in flight
        step_ab(1'b1, 1'b1);
        step_ab(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_sum", {16'd0, sum}, 32'd0);
            chk("midrst_cout", {31'd0, cout}, 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("midrst_no_stale", q.size(), 0);

        // Random stress with handshake toggling
        base = accepted;
        cyc  = 0;
        while (accepted - base < 10000 && cyc < 60000) begin
            step_ab(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0));
            cyc++;
        end
        chk("stress_accepted", accepted - base, 10000);
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
